// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, sample type, FSM states and halving helper for the FFT stages
package fft_pkg;
  localparam int DW = 12;
  localparam int N = 8;
  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [DW:0] wide_t;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic wide_t ext(sample_t v);
    return {v[DW-1], v};
  endfunction
  function automatic sample_t half(wide_t v);
    return sample_t'(v >>> 1);
  endfunction
endpackage

// File: rtl/fft_bfly2.sv
// fft_bfly2: combinational radix-2 DIF butterfly with halving and optional -j twiddle
import fft_pkg::*;
module fft_bfly2 (
  input  sample_t a_re,
  input  sample_t a_im,
  input  sample_t b_re,
  input  sample_t b_im,
  input  logic    neg_j,
  output sample_t top_re,
  output sample_t top_im,
  output sample_t bot_re,
  output sample_t bot_im
);
  wide_t s_re, s_im, d_re, d_im, n_re;
  // one extra bit of headroom makes the sum/difference exact before halving
  always_comb begin
    s_re = ext(a_re) + ext(b_re);
    s_im = ext(a_im) + ext(b_im);
    d_re = ext(a_re) - ext(b_re);
    d_im = ext(a_im) - ext(b_im);
    n_re = ext(b_re) - ext(a_re);
    top_re = half(s_re);
    top_im = half(s_im);
    bot_re = neg_j ? half(d_im) : half(d_re);
    bot_im = neg_j ? half(n_re) : half(d_im);
  end
endmodule

// File: rtl/fft_stage2.sv
// fft_stage2: second 8-point DIF stage, one time-shared butterfly per cycle over a latched frame
module fft_stage2 #(
  parameter int DW = fft_pkg::DW,
  parameter int N  = fft_pkg::N
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 START,
  input  logic signed [DW-1:0] x_in_real      [0:7],
  input  logic signed [DW-1:0] x_in_image     [0:7],
  output logic signed [DW-1:0] x_stage2_real  [0:7],
  output logic signed [DW-1:0] x_stage2_image [0:7],
  output logic                 stage2_done,
  output logic                 busy,
  output logic                 overrun
);
  localparam logic [1:0] LAST = 2'(N / 2 - 1);
  fft_pkg::state_t state, state_nx;
  logic [1:0] cnt;
  logic signed [DW-1:0] fr_re [0:7];
  logic signed [DW-1:0] fr_im [0:7];
  logic [2:0] ia, ib;
  logic last, load;
  fft_pkg::sample_t t_re, t_im, b_re, b_im;
  // butterfly cnt pairs slots {c1,0,c0} and {c1,1,c0}; odd butterflies use -j
  assign ia = {cnt[1], 1'b0, cnt[0]};
  assign ib = {cnt[1], 1'b1, cnt[0]};
  assign last = (state == fft_pkg::RUN) && (cnt == LAST);
  assign load = START && ((state == fft_pkg::IDLE) || last);
  fft_bfly2 u_bfly (
    .a_re(fr_re[ia]),
    .a_im(fr_im[ia]),
    .b_re(fr_re[ib]),
    .b_im(fr_im[ib]),
    .neg_j(cnt[0]),
    .top_re(t_re),
    .top_im(t_im),
    .bot_re(b_re),
    .bot_im(b_im)
  );
  // state register
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) state <= fft_pkg::IDLE;
    else state <= state_nx;
  // next state: a new frame keeps us running, finishing the last butterfly otherwise idles
  always_comb state_nx = load ? fft_pkg::RUN : (last ? fft_pkg::IDLE : state);
  // state-decoded outputs
  always_comb busy = (state == fft_pkg::RUN);
  // butterfly counter and frame buffer, reloaded on every accepted START
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        fr_re[i] <= '0;
        fr_im[i] <= '0;
      end
    end else if (load) begin
      cnt <= '0;
      fr_re <= x_in_real;
      fr_im <= x_in_image;
    end else if (busy) cnt <= cnt + 2'd1;
  // result slots written two at a time, otherwise held
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      for (int i = 0; i < 8; i++) begin
        x_stage2_real[i] <= '0;
        x_stage2_image[i] <= '0;
      end
    end else if (busy) begin
      x_stage2_real[ia] <= t_re;
      x_stage2_image[ia] <= t_im;
      x_stage2_real[ib] <= b_re;
      x_stage2_image[ib] <= b_im;
    end
  // completion pulse and sticky dropped-START flag
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      stage2_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      stage2_done <= last;
      overrun <= overrun | (START && busy && !last);
    end
endmodule
